// File: rtl/noc_packetizer_pkg.sv
// Shared NoC header layout and local stream types for the packetizer and the router arbiter.
// The router decodes noc_header_t from TDATA, so any field change here must land in both places.
package noc_packetizer_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int MAX_ROUTERS_X   = 4;
    localparam int MAX_ROUTERS_Y   = 4;
    localparam int MAX_PAYLOAD     = 16;

    localparam int X_W   = $clog2(MAX_ROUTERS_X);
    localparam int Y_W   = $clog2(MAX_ROUTERS_Y);
    localparam int LEN_W = $clog2(MAX_PAYLOAD);

    localparam int DST_X_OFF  = 0;
    localparam int DST_Y_OFF  = DST_X_OFF + X_W;
    localparam int SRC_X_OFF  = DST_Y_OFF + Y_W;
    localparam int SRC_Y_OFF  = SRC_X_OFF + X_W;
    localparam int LEN_OFF    = SRC_Y_OFF + Y_W;
    localparam int HDR_USED_W = LEN_OFF + LEN_W;
    localparam int HDR_PAD_W  = AXIS_DATA_WIDTH - HDR_USED_W;

    // Declared MSB first, so dstX lands on bit 0 of TDATA.
    typedef struct packed {
        logic [HDR_PAD_W-1:0] pad;
        logic [LEN_W-1:0]     len;
        logic [Y_W-1:0]       srcY;
        logic [X_W-1:0]       srcX;
        logic [Y_W-1:0]       dstY;
        logic [X_W-1:0]       dstX;
    } noc_header_t;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic                       tvalid;
        logic                       tlast;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } pkt_state_e;

    function automatic noc_header_t buildHeader(
        input logic [X_W-1:0]   dstX,
        input logic [Y_W-1:0]   dstY,
        input logic [X_W-1:0]   srcX,
        input logic [Y_W-1:0]   srcY,
        input logic [LEN_W-1:0] len
    );
        noc_header_t hdr;
        hdr      = '0;
        hdr.dstX = dstX;
        hdr.dstY = dstY;
        hdr.srcX = srcX;
        hdr.srcY = srcY;
        hdr.len  = len;
        return hdr;
    endfunction

endpackage

// File: rtl/noc_packetizer_credit.sv
// Outstanding-packet counter: +1 per sent packet, -1 per returned response, saturating,
// with a sticky error when a response arrives while nothing is outstanding.
module noc_credit_counter
    import noc_packetizer_pkg::*;
#(
    parameter int MAX   = 5,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // A simultaneous send and response cancel out and leave the count alone.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc_i && !dec_i) begin
            if (count_q != CNT_W'(MAX)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/noc_packetizer.sv
// Transmit-side NoC endpoint: wraps a command plus a raw payload stream into a header-first
// AXI-Stream packet for the router, throttled by an outstanding-response credit count.
module noc_packetizer
    import noc_packetizer_pkg::*;
#(
    parameter  int ROUTER_X                = 0,
    parameter  int ROUTER_Y                = 0,
    parameter  int MAXIMUM_PACKAGES_NUMBER = 5,
    localparam int CNT_W                   = $clog2(MAXIMUM_PACKAGES_NUMBER + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [X_W-1:0]             cmd_x_i,
    input  logic [Y_W-1:0]             cmd_y_i,
    input  logic [LEN_W-1:0]           cmd_len_i,
    input  logic                       pld_valid_i,
    output logic                       pld_ready_o,
    input  logic [AXIS_DATA_WIDTH-1:0] pld_data_i,
    output axis_mosi_t                 out_mosi_o,
    input  axis_miso_t                 out_miso_i,
    input  logic                       resp_done_i,
    output logic [CNT_W-1:0]           outstanding_o,
    output logic                       credit_err_o
);

    pkt_state_e       state_q;
    noc_header_t      hdr_q;
    logic             hdrValid_q;
    logic [LEN_W-1:0] beatCnt_q;
    logic             live_q;
    logic             cmdFire;
    logic             pldFire;
    logic             lastBeat;

    // live_q keeps cmd_ready_o low until the first clock edge after reset is released.
    assign cmd_ready_o = live_q && (state_q == IDLE)
                         && (outstanding_o < CNT_W'(MAXIMUM_PACKAGES_NUMBER));
    assign cmdFire     = cmd_valid_i && cmd_ready_o;
    assign pld_ready_o = (state_q == PAYLOAD) && out_miso_i.tready;
    assign pldFire     = pld_valid_i && pld_ready_o;
    assign lastBeat    = (beatCnt_q == hdr_q.len);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            hdrValid_q <= 1'b0;
            beatCnt_q  <= '0;
            live_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (cmdFire) begin
                        hdr_q      <= buildHeader(cmd_x_i, cmd_y_i, X_W'(ROUTER_X),
                                                  Y_W'(ROUTER_Y), cmd_len_i);
                        hdrValid_q <= 1'b1;
                        state_q    <= HEADER;
                    end
                end
                HEADER: begin
                    if (out_miso_i.tready) begin
                        hdrValid_q <= 1'b0;
                        beatCnt_q  <= '0;
                        state_q    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pldFire) begin
                        if (lastBeat) begin
                            state_q <= IDLE;
                        end else begin
                            beatCnt_q <= beatCnt_q + LEN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload beats bypass any register so the upstream source sees TREADY directly.
    always_comb begin
        out_mosi_o = '0;
        case (state_q)
            HEADER: begin
                out_mosi_o.tdata  = hdr_q;
                out_mosi_o.tvalid = hdrValid_q;
            end
            PAYLOAD: begin
                out_mosi_o.tdata  = pld_data_i;
                out_mosi_o.tvalid = pld_valid_i;
                out_mosi_o.tlast  = lastBeat;
            end
            default: out_mosi_o = '0;
        endcase
    end

    noc_credit_counter #(
        .MAX   (MAXIMUM_PACKAGES_NUMBER),
        .CNT_W (CNT_W)
    ) u_credit (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (cmdFire),
        .dec_i   (resp_done_i),
        .count_o (outstanding_o),
        .err_o   (credit_err_o)
    );

endmodule
